// File: rtl/piece_controller_pkg.sv
// Shared encodings for the falling-piece sequencer: shape codes, FSM states,
// request kinds and the sticky pending-request set.
package piece_controller_pkg;

    typedef enum logic [2:0] {
        SH_NONE = 3'd0,
        SH_T    = 3'd1,
        SH_Z    = 3'd2,
        SH_S    = 3'd3,
        SH_J    = 3'd4,
        SH_L    = 3'd5,
        SH_O    = 3'd6,
        SH_I    = 3'd7
    } shape_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_QUERY,
        ST_EVAL,
        ST_READY,
        ST_LOCK,
        ST_GAMEOVER
    } state_t;

    typedef enum logic [2:0] {
        REQ_SPAWN,
        REQ_ROT,
        REQ_LEFT,
        REQ_RIGHT,
        REQ_DROP,
        REQ_TICK
    } req_kind_t;

    typedef struct packed {
        logic rot;
        logic left;
        logic right;
        logic drop;
        logic tick;
    } pend_t;

endpackage

// File: rtl/piece_controller.sv
// Active-tetromino sequencer: serves one pending move at a time, checks it against the board
// window (move request to commit = 2 cycles after the READY pick), holds lock_valid until lock_ack.
module piece_controller
    import piece_controller_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int SPAWN_X = 3,
    parameter int XW      = 4,
    parameter int YW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    rnd,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_rot,
    input  logic          btn_drop,
    input  logic          tick,
    output logic [2:0]    rom_shape,
    output logic [1:0]    rom_rot,
    input  logic [15:0]   rom_block,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    input  logic [15:0]   board_win,
    output logic [XW-1:0] piece_x,
    output logic [YW-1:0] piece_y,
    output logic [2:0]    piece_shape,
    output logic [1:0]    piece_rot,
    output logic          lock_valid,
    input  logic          lock_ack,
    output logic          game_over
);

    localparam logic [XW-1:0] X_SPAWN = XW'(SPAWN_X);
    localparam logic [XW-1:0] X_MAX   = {XW{1'b1}};
    localparam logic [XW:0]   X_LIM   = (XW+1)'(BOARD_W);
    localparam logic [YW:0]   Y_LIM   = (YW+1)'(BOARD_H);

    state_t        state, state_nxt;
    shape_t        pshape, pshape_nxt;
    logic [XW-1:0] px, px_nxt, cx, cx_nxt;
    logic [YW-1:0] py, py_nxt, cy, cy_nxt;
    logic [1:0]    prot, prot_nxt, crot, crot_nxt;
    req_kind_t     kind, kind_nxt;
    pend_t         pend, pend_nxt;
    logic          drop_act, drop_nxt;
    logic          querying;
    logic          oob;
    logic          hit;

    assign querying = (state == ST_QUERY) || (state == ST_EVAL);

    assign rom_shape   = pshape;
    assign rom_rot     = querying ? crot : prot;
    assign win_x       = querying ? cx : px;
    assign win_y       = querying ? cy : py;
    assign piece_x     = px;
    assign piece_y     = py;
    assign piece_shape = pshape;
    assign piece_rot   = prot;
    assign lock_valid  = (state == ST_LOCK);
    assign game_over   = (state == ST_GAMEOVER);

    // A window entirely off the board always collides; this also stops y from wrapping on a long drop.
    assign oob = ({1'b0, cx} >= X_LIM) || ({1'b0, cy} >= Y_LIM);
    assign hit = oob || (|(rom_block & board_win));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pshape   <= SH_O;
            px       <= '0;
            py       <= '0;
            prot     <= '0;
            cx       <= '0;
            cy       <= '0;
            crot     <= '0;
            kind     <= REQ_SPAWN;
            pend     <= '0;
            drop_act <= 1'b0;
        end else begin
            state    <= state_nxt;
            pshape   <= pshape_nxt;
            px       <= px_nxt;
            py       <= py_nxt;
            prot     <= prot_nxt;
            cx       <= cx_nxt;
            cy       <= cy_nxt;
            crot     <= crot_nxt;
            kind     <= kind_nxt;
            pend     <= pend_nxt;
            drop_act <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pshape_nxt = pshape;
        px_nxt     = px;
        py_nxt     = py;
        prot_nxt   = prot;
        cx_nxt     = cx;
        cy_nxt     = cy;
        crot_nxt   = crot;
        kind_nxt   = kind;
        pend_nxt   = pend;
        drop_nxt   = drop_act;

        case (state)
            ST_IDLE, ST_GAMEOVER: begin
                pend_nxt = '0;
                drop_nxt = 1'b0;
                if (start) state_nxt = ST_SPAWN;
            end
            ST_SPAWN: begin
                pshape_nxt = (rnd == 3'd0) ? SH_O : shape_t'(rnd);
                cx_nxt     = X_SPAWN;
                cy_nxt     = '0;
                crot_nxt   = '0;
                kind_nxt   = REQ_SPAWN;
                state_nxt  = ST_QUERY;
            end
            ST_QUERY: state_nxt = ST_EVAL;
            ST_EVAL: begin
                state_nxt = ST_READY;
                if (!hit) begin
                    px_nxt   = cx;
                    py_nxt   = cy;
                    prot_nxt = crot;
                end
                case (kind)
                    REQ_SPAWN: if (hit) state_nxt = ST_GAMEOVER;
                    REQ_TICK:  if (hit) state_nxt = ST_LOCK;
                    REQ_DROP: begin
                        if (hit) begin
                            state_nxt = ST_LOCK;
                            drop_nxt  = 1'b0;
                        end else begin
                            cy_nxt    = cy + YW'(1);
                            state_nxt = ST_QUERY;
                        end
                    end
                    default: ;
                endcase
            end
            ST_READY: begin
                cx_nxt   = px;
                cy_nxt   = py;
                crot_nxt = prot;
                if (pend.rot) begin
                    pend_nxt.rot = 1'b0;
                    crot_nxt     = prot + 2'd1;
                    kind_nxt     = REQ_ROT;
                    state_nxt    = ST_QUERY;
                end else if (pend.left) begin
                    pend_nxt.left = 1'b0;
                    if (px != '0) begin
                        cx_nxt    = px - XW'(1);
                        kind_nxt  = REQ_LEFT;
                        state_nxt = ST_QUERY;
                    end
                end else if (pend.right) begin
                    pend_nxt.right = 1'b0;
                    if (px != X_MAX) begin
                        cx_nxt    = px + XW'(1);
                        kind_nxt  = REQ_RIGHT;
                        state_nxt = ST_QUERY;
                    end
                end else if (pend.drop) begin
                    pend_nxt.drop = 1'b0;
                    drop_nxt      = 1'b1;
                    cy_nxt        = py + YW'(1);
                    kind_nxt      = REQ_DROP;
                    state_nxt     = ST_QUERY;
                end else if (pend.tick) begin
                    pend_nxt.tick = 1'b0;
                    cy_nxt        = py + YW'(1);
                    kind_nxt      = REQ_TICK;
                    state_nxt     = ST_QUERY;
                end
            end
            ST_LOCK: if (lock_ack) state_nxt = ST_SPAWN;
            default: state_nxt = ST_IDLE;
        endcase

        // New requests win over the clear of the one just served.
        if (state != ST_IDLE && state != ST_GAMEOVER) begin
            pend_nxt.rot   = pend_nxt.rot   | btn_rot;
            pend_nxt.left  = pend_nxt.left  | btn_left;
            pend_nxt.right = pend_nxt.right | btn_right;
            pend_nxt.drop  = pend_nxt.drop  | btn_drop;
            pend_nxt.tick  = pend_nxt.tick  | tick;
        end
        if (drop_nxt) begin
            pend_nxt.rot   = 1'b0;
            pend_nxt.left  = 1'b0;
            pend_nxt.right = 1'b0;
        end
        if (state == ST_LOCK && lock_ack) pend_nxt = '0;
    end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller with shape-ROM and board-window models and a piece scoreboard.
module tb_piece_controller;

    logic        clk = 1'b0;
    logic        rst, start, btn_left, btn_right, btn_rot, btn_drop, tick, lock_ack;
    logic [2:0]  rnd;
    logic [2:0]  rom_shape, piece_shape;
    logic [1:0]  rom_rot, piece_rot;
    logic [15:0] rom_block;
    logic [15:0] board_win = '0;
    logic [3:0]  win_x, piece_x;
    logic [4:0]  win_y, piece_y;
    logic        lock_valid, game_over;
    logic        force_full = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] x;
        logic [4:0] y;
        logic [2:0] sh;
        logic [1:0] rot;
    } pc_t;
    pc_t exp_q[$];

    always #5 clk = ~clk;

    piece_controller dut (
        .clk(clk), .rst(rst), .start(start), .rnd(rnd),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot),
        .btn_drop(btn_drop), .tick(tick),
        .rom_shape(rom_shape), .rom_rot(rom_rot), .rom_block(rom_block),
        .win_x(win_x), .win_y(win_y), .board_win(board_win),
        .piece_x(piece_x), .piece_y(piece_y), .piece_shape(piece_shape),
        .piece_rot(piece_rot), .lock_valid(lock_valid), .lock_ack(lock_ack),
        .game_over(game_over)
    );

    // Shape ROM model: T in all four rotations, O square, everything else a flat bar.
    always_comb begin
        rom_block = 16'h0F00;
        case (rom_shape)
            3'd1: case (rom_rot)
                2'd0: rom_block = 16'h4E00;
                2'd1: rom_block = 16'h4640;
                2'd2: rom_block = 16'h0E40;
                default: rom_block = 16'h4C40;
            endcase
            3'd6: rom_block = 16'h6600;
            default: rom_block = 16'h0F00;
        endcase
    end

    // Empty 10x20 board; off-board cells read as occupied, force_full makes every cell occupied.
    always @(posedge clk) begin : board_model
        logic [15:0] w;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w[15 - (r * 4 + c)] = force_full || ((int'(win_x) + c) >= 10) || ((int'(win_y) + r) >= 20);
            end
        end
        board_win <= w;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int sh, input int rot);
        pc_t e;
        e.x = 4'(x);
        e.y = 5'(y);
        e.sh = 3'(sh);
        e.rot = 2'(rot);
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        pc_t e;
        pc_t obs;
        obs = {piece_x, piece_y, piece_shape, piece_rot};
        if (exp_q.size() == 0) begin
            chk({tag, "_empty_queue"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(obs), 32'(e));
        end
    endtask

    // Drives a one-cycle pulse on the selected request lines.
    task automatic pulse(input logic r, input logic l, input logic rt, input logic d, input logic t);
        btn_rot = r; btn_left = l; btn_right = rt; btn_drop = d; tick = t;
        step(1);
        btn_rot = 0; btn_left = 0; btn_right = 0; btn_drop = 0; tick = 0;
    endtask

    task automatic do_start(input logic [2:0] r);
        rnd = r;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; rnd = 0; lock_ack = 0;
        btn_left = 0; btn_right = 0; btn_rot = 0; btn_drop = 0; tick = 0;
        step(2);
        chk("rst_piece_xy", {piece_x, piece_y, piece_rot}, 0);
        chk("rst_piece_shape", piece_shape, 6);
        chk("rst_rom_shape", rom_shape, 6);
        chk("rst_rom_win", {rom_rot, win_x, win_y}, 0);
        chk("rst_flags", {lock_valid, game_over}, 0);
        rst = 1'b0;
        step(1);

        // Spawn: commit lands 2 cycles after the candidate query begins.
        push(3, 0, 1, 0);
        do_start(3'd1);
        step(2);
        chk("spawn_not_yet", piece_x, 0);
        step(1);
        pop_check("spawn_T");
        chk("spawn_no_gameover", game_over, 0);

        // Gravity ticks.
        for (int i = 1; i <= 3; i++) begin
            push(3, i, 1, 0);
            pulse(0, 0, 0, 0, 1);
            step(2);
            chk("tick_latency", piece_y, 5'(i - 1));
            step(1);
            pop_check("tick_commit");
        end

        // Walk to the left wall, then the rejected moves.
        for (int i = 2; i >= 0; i--) begin
            push(i, 3, 1, 0);
            pulse(0, 1, 0, 0, 0);
            step(3);
            pop_check("left_commit");
        end
        push(0, 3, 1, 0);
        pulse(0, 1, 0, 0, 0);
        step(1);
        chk("left_at_0_no_query", win_x, 0);
        step(2);
        pop_check("left_at_0_kept");
        force_full = 1'b1;
        push(0, 3, 1, 0);
        pulse(0, 0, 1, 0, 0);
        step(1);
        chk("right_query_cand", win_x, 1);
        step(2);
        pop_check("right_wall_rejected");
        force_full = 1'b0;

        // Fresh piece for the priority test.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push(3, 0, 1, 0);
        do_start(3'd1);
        step(3);
        pop_check("respawn");

        push(3, 0, 1, 1);
        push(2, 0, 1, 1);
        push(2, 1, 1, 1);
        pulse(1, 1, 0, 0, 1);
        step(3);
        pop_check("prio_rot");
        step(3);
        pop_check("prio_left");
        step(3);
        pop_check("prio_tick");

        // Hard drop to the floor; left and tick raised mid-drop must not survive the lock.
        push(2, 2, 1, 1);
        pulse(0, 0, 0, 1, 0);
        step(3);
        pop_check("drop_first");
        for (int k = 3; k <= 17; k++) begin
            if (k == 10) begin
                pulse(0, 1, 0, 0, 1);
                step(1);
            end else begin
                step(2);
            end
            push(2, k, 1, 1);
            pop_check("drop_step");
        end
        step(1);
        chk("drop_no_lock_yet", lock_valid, 0);
        step(1);
        chk("lock_valid_up", lock_valid, 1);
        push(2, 17, 1, 1);
        pop_check("lock_piece");
        chk("lock_rom_rot", rom_rot, 1);
        step(5);
        chk("lock_held", lock_valid, 1);
        lock_ack = 1'b1;
        rnd = 3'd0;
        step(1);
        lock_ack = 1'b0;
        chk("lock_released", lock_valid, 0);
        push(3, 0, 6, 0);
        step(3);
        pop_check("spawn_O_after_lock");
        lock_ack = 1'b1;
        step(1);
        lock_ack = 1'b0;
        step(5);
        push(3, 0, 6, 0);
        pop_check("pending_cleared_at_lock");
        chk("stray_ack_no_lock", lock_valid, 0);

        // Drop the O, then spawn into a full window.
        pulse(0, 0, 0, 1, 0);
        for (int i = 0; i < 100 && !lock_valid; i++) step(1);
        chk("O_lock_seen", lock_valid, 1);
        push(3, 18, 6, 0);
        pop_check("O_lock_row");
        force_full = 1'b1;
        lock_ack = 1'b1;
        rnd = 3'd1;
        step(1);
        lock_ack = 1'b0;
        step(3);
        chk("game_over_set", game_over, 1);
        pulse(0, 1, 0, 1, 0);
        step(4);
        chk("game_over_held", {game_over, lock_valid}, 2'b10);
        force_full = 1'b0;
        push(3, 0, 1, 0);
        do_start(3'd1);
        chk("game_over_cleared", game_over, 0);
        step(3);
        pop_check("restart_spawn");
        step(4);
        push(3, 0, 1, 0);
        pop_check("gameover_buttons_ignored");

        // Reset in the middle of a drop.
        pulse(0, 0, 0, 1, 0);
        step(5);
        rst = 1'b1;
        #1;
        chk("midreset_piece", {piece_x, piece_y, piece_rot}, 0);
        chk("midreset_shape", {piece_shape, rom_shape}, {3'd6, 3'd6});
        chk("midreset_flags", {lock_valid, game_over}, 0);
        step(2);
        rst = 1'b0;
        step(4);
        chk("idle_after_reset", {piece_y, lock_valid}, 0);
        push(3, 0, 1, 0);
        do_start(3'd1);
        step(3);
        pop_check("post_reset_spawn");
        step(6);
        chk("no_stale_drop", piece_y, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
